// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline hazard control bus: stage register/control inputs and the
// stall, flush and forwarding controls returned to the datapath.
interface pipe_hazard_ctrl_if;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  ex_rs1;
  logic [4:0]  ex_rs2;
  logic [4:0]  ex_rd;
  logic        ex_memread;
  logic        ex_branch_taken;
  logic [4:0]  mem_rd;
  logic        mem_regwrite;
  logic        mem_memread;
  logic        mem_memwrite;
  logic [4:0]  wb_rd;
  logic        wb_regwrite;
  logic        dmem_ready;

  logic        pc_write;
  logic        ifid_write;
  logic        ifid_flush;
  logic        idex_hold;
  logic        idex_bubble;
  logic        exmem_hold;
  logic        memwb_bubble;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic        mem_timeout;
  logic [15:0] stall_cycles;

  // Datapath side: drives stage information, consumes controls.
  modport master (
    output id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, ex_memread, ex_branch_taken,
           mem_rd, mem_regwrite, mem_memread, mem_memwrite, wb_rd, wb_regwrite,
           dmem_ready,
    input  pc_write, ifid_write, ifid_flush, idex_hold, idex_bubble,
           exmem_hold, memwb_bubble, fwd_a, fwd_b, mem_timeout, stall_cycles
  );

  // Hazard unit side.
  modport slave (
    input  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, ex_memread, ex_branch_taken,
           mem_rd, mem_regwrite, mem_memread, mem_memwrite, wb_rd, wb_regwrite,
           dmem_ready,
    output pc_write, ifid_write, ifid_flush, idex_hold, idex_bubble,
           exmem_hold, memwb_bubble, fwd_a, fwd_b, mem_timeout, stall_cycles
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard controller: load-use stall, taken-branch
// flush, data-memory wait freeze with timeout, and ALU operand forwarding.
module pipe_hazard_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input logic                clk,
  input logic                reset,
  pipe_hazard_ctrl_if.slave  bus
);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      state_next;
  logic [7:0]  wait_cnt;
  logic        mem_timeout;
  logic [15:0] stall_cycles;
  logic        mem_busy;
  logic        load_use;

  logic        pc_write;
  logic        ifid_write;
  logic        ifid_flush;
  logic        idex_hold;
  logic        idex_bubble;
  logic        exmem_hold;
  logic        memwb_bubble;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;

  // Hazard detection terms from the current stage contents.
  always_comb begin
    mem_busy = (bus.mem_memread | bus.mem_memwrite) & ~bus.dmem_ready;
    load_use = bus.ex_memread && (bus.ex_rd != 5'd0) &&
               ((bus.ex_rd == bus.id_rs1) || (bus.ex_rd == bus.id_rs2));
  end

  // Next state and pipeline controls; freeze outranks branch, branch outranks load-use.
  always_comb begin
    state_next   = state;
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_hold    = 1'b0;
    idex_bubble  = 1'b0;
    exmem_hold   = 1'b0;
    memwb_bubble = 1'b0;
    if (reset) begin
      state_next = RUN;
    end else begin
      unique case (state)
        RUN:      if (mem_busy)  state_next = MEM_WAIT;
        MEM_WAIT: if (!mem_busy) state_next = RUN;
        default:  state_next = RUN;
      endcase
      if (mem_busy) begin
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        idex_hold    = 1'b1;
        exmem_hold   = 1'b1;
        memwb_bubble = 1'b1;
      end else if (bus.ex_branch_taken) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end else if (load_use) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
    end
  end

  // Operand forwarding: MEM stage has priority over WB, x0 never forwarded.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (!reset) begin
      if (bus.mem_regwrite && bus.mem_rd != 5'd0 && bus.mem_rd == bus.ex_rs1)
        fwd_a = 2'b10;
      else if (bus.wb_regwrite && bus.wb_rd != 5'd0 && bus.wb_rd == bus.ex_rs1)
        fwd_a = 2'b01;
      if (bus.mem_regwrite && bus.mem_rd != 5'd0 && bus.mem_rd == bus.ex_rs2)
        fwd_b = 2'b10;
      else if (bus.wb_regwrite && bus.wb_rd != 5'd0 && bus.wb_rd == bus.ex_rs2)
        fwd_b = 2'b01;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  // Consecutive wait-cycle counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else if (state == MEM_WAIT) begin
      if (wait_cnt != '1) wait_cnt <= wait_cnt + 8'd1;
      if (wait_cnt == TIMEOUT_LAST) mem_timeout <= 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  // Saturating count of cycles in which the PC did not advance.
  always_ff @(posedge clk) begin
    if (reset)
      stall_cycles <= '0;
    else if (!pc_write && stall_cycles != '1)
      stall_cycles <= stall_cycles + 16'd1;
  end

  // Drive the bus outputs.
  always_comb begin
    bus.pc_write     = pc_write;
    bus.ifid_write   = ifid_write;
    bus.ifid_flush   = ifid_flush;
    bus.idex_hold    = idex_hold;
    bus.idex_bubble  = idex_bubble;
    bus.exmem_hold   = exmem_hold;
    bus.memwb_bubble = memwb_bubble;
    bus.fwd_a        = fwd_a;
    bus.fwd_b        = fwd_b;
    bus.mem_timeout  = mem_timeout;
    bus.stall_cycles = stall_cycles;
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed, table-driven bench for pipe_hazard_ctrl.
module tb_pipe_hazard_ctrl;

  typedef struct {
    logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd;
    logic        ex_memread, ex_br;
    logic [4:0]  mem_rd;
    logic        mem_rw, mem_mr, mem_mw;
    logic [4:0]  wb_rd;
    logic        wb_rw, ready;
    logic [10:0] exp;
    logic [15:0] exp_stall;
  } vec_t;

  // {pc_write, ifid_write, ifid_flush, idex_hold, idex_bubble, exmem_hold, memwb_bubble}
  localparam logic [6:0] NORM = 7'b1100000;
  localparam logic [6:0] LU   = 7'b0000100;
  localparam logic [6:0] BR   = 7'b1110100;
  localparam logic [6:0] FRZ  = 7'b0001011;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  vec_t tbl[18];

  pipe_hazard_ctrl_if hz();

  pipe_hazard_ctrl #(.TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (hz.slave)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic [4:0] id1, id2, ex1, ex2, exrd,
    input logic exmr, br,
    input logic [4:0] mrd, input logic mrw, mmr, mmw,
    input logic [4:0] wrd, input logic wrw, rdy,
    input logic [6:0] ctl, input logic [1:0] fa, fb, input logic [15:0] st);
    vec_t v;
    v.id_rs1 = id1; v.id_rs2 = id2; v.ex_rs1 = ex1; v.ex_rs2 = ex2; v.ex_rd = exrd;
    v.ex_memread = exmr; v.ex_br = br;
    v.mem_rd = mrd; v.mem_rw = mrw; v.mem_mr = mmr; v.mem_mw = mmw;
    v.wb_rd = wrd; v.wb_rw = wrw; v.ready = rdy;
    v.exp = {ctl, fa, fb}; v.exp_stall = st;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    hz.id_rs1 = v.id_rs1; hz.id_rs2 = v.id_rs2;
    hz.ex_rs1 = v.ex_rs1; hz.ex_rs2 = v.ex_rs2; hz.ex_rd = v.ex_rd;
    hz.ex_memread = v.ex_memread; hz.ex_branch_taken = v.ex_br;
    hz.mem_rd = v.mem_rd; hz.mem_regwrite = v.mem_rw;
    hz.mem_memread = v.mem_mr; hz.mem_memwrite = v.mem_mw;
    hz.wb_rd = v.wb_rd; hz.wb_regwrite = v.wb_rw; hz.dmem_ready = v.ready;
  endtask

  function automatic logic [10:0] outs();
    return {hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.idex_hold, hz.idex_bubble,
            hz.exmem_hold, hz.memwb_bubble, hz.fwd_a, hz.fwd_b};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    vec_t wild;
    tbl[0]  = mk(1,2,0,0,0, 0,0, 0,0,0,0, 0,0,1, NORM,2'b00,2'b00, 0);
    tbl[1]  = mk(4,5,0,0,5, 1,0, 0,0,0,0, 0,0,1, LU,  2'b00,2'b00, 1);
    tbl[2]  = mk(5,4,0,0,5, 1,0, 0,0,0,0, 0,0,1, LU,  2'b00,2'b00, 2);
    tbl[3]  = mk(0,0,0,0,0, 1,0, 0,0,0,0, 0,0,1, NORM,2'b00,2'b00, 2);
    tbl[4]  = mk(6,7,0,0,5, 1,0, 0,0,0,0, 0,0,1, NORM,2'b00,2'b00, 2);
    tbl[5]  = mk(5,5,0,0,5, 1,1, 0,0,0,0, 0,0,1, BR,  2'b00,2'b00, 2);
    tbl[6]  = mk(1,2,0,0,0, 0,1, 0,0,0,0, 0,0,1, BR,  2'b00,2'b00, 2);
    tbl[7]  = mk(5,1,0,0,5, 1,1, 0,0,1,0, 0,0,0, FRZ, 2'b00,2'b00, 3);
    tbl[8]  = mk(1,2,0,0,0, 0,0, 0,0,0,1, 0,0,0, FRZ, 2'b00,2'b00, 4);
    tbl[9]  = mk(1,2,0,0,0, 0,0, 0,0,1,0, 0,0,1, NORM,2'b00,2'b00, 4);
    tbl[10] = mk(0,0,7,0,0, 0,0, 7,1,0,0, 7,1,1, NORM,2'b10,2'b00, 4);
    tbl[11] = mk(0,0,0,9,0, 0,0, 0,0,0,0, 9,1,1, NORM,2'b00,2'b01, 4);
    tbl[12] = mk(0,0,7,0,0, 0,0, 7,0,0,0, 7,1,1, NORM,2'b01,2'b00, 4);
    tbl[13] = mk(0,0,0,0,0, 0,0, 0,1,0,0, 0,1,1, NORM,2'b00,2'b00, 4);
    tbl[14] = mk(0,0,3,3,0, 0,0, 3,1,0,0, 8,1,1, NORM,2'b10,2'b10, 4);
    tbl[15] = mk(0,0,7,9,0, 0,0, 7,1,1,0, 9,1,0, FRZ, 2'b10,2'b01, 5);
    tbl[16] = mk(0,0,0,0,0, 0,0, 0,0,1,0, 0,0,1, NORM,2'b00,2'b00, 5);
    tbl[17] = mk(0,0,0,6,0, 0,0, 6,1,0,0, 6,1,1, NORM,2'b00,2'b10, 5);

    // Reset with every hazard asserted at once.
    wild = mk(5,5,7,7,5, 1,1, 7,1,1,1, 7,1,0, NORM,2'b00,2'b00, 0);
    reset = 1'b1;
    apply(wild);
    #1;
    check("reset_outs", 32'(outs()), {21'd0, NORM, 4'b0000});
    tick();
    tick();
    check("reset_stall", 32'(hz.stall_cycles), 32'd0);
    check("reset_timeout", 32'(hz.mem_timeout), 32'd0);
    apply(tbl[0]);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 18; i++) begin
      apply(tbl[i]);
      #1;
      check($sformatf("vec%0d_outs", i), 32'(outs()), 32'(tbl[i].exp));
      tick();
      check($sformatf("vec%0d_stall", i), 32'(hz.stall_cycles), 32'(tbl[i].exp_stall));
    end

    // Memory wait: three frozen cycles, then ready releases the pipeline.
    apply(mk(0,0,0,0,0, 0,0, 0,0,1,0, 0,0,0, NORM,2'b00,2'b00, 0));
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("memwait_frz%0d", k), 32'(outs()), {21'd0, FRZ, 4'b0000});
      tick();
    end
    hz.dmem_ready = 1'b1;
    #1;
    check("memwait_release", 32'(outs()), {21'd0, NORM, 4'b0000});
    tick();
    check("memwait_stall", 32'(hz.stall_cycles), 32'd8);
    check("memwait_no_timeout", 32'(hz.mem_timeout), 32'd0);

    // Timeout: flag rises after 16 cycles spent in MEM_WAIT.
    hz.dmem_ready = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      tick();
      if (k == 16) check("timeout_pre", 32'(hz.mem_timeout), 32'd0);
      if (k == 17) check("timeout_set", 32'(hz.mem_timeout), 32'd1);
    end
    hz.dmem_ready = 1'b1;
    tick();
    tick();
    check("timeout_sticky", 32'(hz.mem_timeout), 32'd1);

    // Reset in the middle of a wait.
    hz.dmem_ready = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    hz.ex_rs1 = 5'd7; hz.mem_rd = 5'd7; hz.mem_regwrite = 1'b1;
    #1;
    check("midreset_outs", 32'(outs()), {21'd0, NORM, 4'b0000});
    tick();
    reset = 1'b0;
    hz.mem_memread = 1'b0;
    hz.mem_regwrite = 1'b0;
    #1;
    check("midreset_pc_write", 32'(hz.pc_write), 32'd1);
    check("midreset_stall", 32'(hz.stall_cycles), 32'd0);
    check("midreset_timeout", 32'(hz.mem_timeout), 32'd0);
    tick();
    check("midreset_idle_stall", 32'(hz.stall_cycles), 32'd0);

    // Wait counter restarts from zero after reset.
    hz.mem_memread = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      tick();
      if (k == 16) check("retimeout_pre", 32'(hz.mem_timeout), 32'd0);
      if (k == 17) check("retimeout_set", 32'(hz.mem_timeout), 32'd1);
    end
    check("retimeout_stall", 32'(hz.stall_cycles), 32'd17);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
